// File: rtl/ring_ilk_pkg.sv
// rtl/ring_ilk_pkg.sv - shared types and cyclic run check for the ring interlock
package ring_ilk_pkg;

    typedef enum logic [2:0] {
        OPEN,
        CLOSING,
        CLOSED,
        OPENING,
        FAULT
    } ch_state_t;

    localparam int RING_MAX = 64;

    // True when some window of `limit` cyclically adjacent positions in the n-bit ring is all ones.
    function automatic logic run_violation(input logic [RING_MAX-1:0] mask,
                                           input int n, input int limit);
        logic v;
        logic all_set;
        int   p;
        v = 1'b0;
        for (int s = 0; s < RING_MAX; s++) begin
            if (s < n) begin
                all_set = 1'b1;
                for (int j = 0; j < RING_MAX; j++) begin
                    if (j < limit) begin
                        p = s + j;
                        if (p >= n) p = p - n;
                        if (!mask[p]) all_set = 1'b0;
                    end
                end
                if (all_set) v = 1'b1;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/ilk_channel_fsm.sv
// rtl/ilk_channel_fsm.sv - per-contactor sequencing FSM with feedback timeout
// Fault exit behaviour selected by RING_ILK_STICKY_FAULT_EN.
module ilk_channel_fsm
    import ring_ilk_pkg::*;
#(
    parameter int FB_TIMEOUT = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_grant,
    input  logic i_req,
    input  logic i_fb,
    input  logic i_fault_clr,
    output logic o_open,
    output logic o_busy,
    output logic o_cmd,
    output logic o_fault
);

    localparam int TW = $clog2(FB_TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(FB_TIMEOUT);

    ch_state_t r_state, w_state_nxt;
    logic [TW-1:0] r_timer, w_timer_nxt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= OPEN;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
        end
    end

`ifndef RING_ILK_STICKY_FAULT_EN
    logic w_unused_fault_clr;
    assign w_unused_fault_clr = i_fault_clr;
`endif

    // Feedback is always examined before the timer so a late-but-in-time edge wins.
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        case (r_state)
            OPEN: begin
                if (i_fb) begin
                    w_state_nxt = FAULT;
                end else if (i_grant) begin
                    w_state_nxt = CLOSING;
                    w_timer_nxt = TIMER_LOAD;
                end
            end
            CLOSING: begin
                if (i_fb) begin
                    w_state_nxt = CLOSED;
                end else if (!i_req) begin
                    w_state_nxt = OPENING;
                    w_timer_nxt = TIMER_LOAD;
                end else if (r_timer <= TW'(1)) begin
                    w_state_nxt = FAULT;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer - TW'(1);
                end
            end
            CLOSED: begin
                if (!i_req) begin
                    w_state_nxt = OPENING;
                    w_timer_nxt = TIMER_LOAD;
                end else if (!i_fb) begin
                    w_state_nxt = FAULT;
                end
            end
            OPENING: begin
                if (!i_fb) begin
                    w_state_nxt = OPEN;
                end else if (r_timer <= TW'(1)) begin
                    w_state_nxt = FAULT;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer - TW'(1);
                end
            end
            FAULT: begin
`ifdef RING_ILK_STICKY_FAULT_EN
                if (i_fault_clr && !i_fb) w_state_nxt = OPEN;
`else
                if (!i_fb && !i_req) w_state_nxt = OPEN;
`endif
            end
            default: w_state_nxt = OPEN;
        endcase
    end

    assign o_open  = (r_state == OPEN);
    assign o_busy  = (r_state == CLOSING) || (r_state == OPENING);
    assign o_cmd   = (r_state == CLOSING) || (r_state == CLOSED);
    assign o_fault = (r_state == FAULT);

endmodule

// File: rtl/ring_interlock_ctrl.sv
// rtl/ring_interlock_ctrl.sv - ring contactor interlock: ring rule, round-robin grant, channel FSMs
// Optional sticky fault handling via RING_ILK_STICKY_FAULT_EN.
module ring_interlock_ctrl
    import ring_ilk_pkg::*;
#(
    parameter int N_CH       = 8,
    parameter int RUN_LIMIT  = 3,
    parameter int FB_TIMEOUT = 16
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [N_CH-1:0] i_req,
    input  logic [N_CH-1:0] i_fb,
    input  logic            i_fault_clr,
    output logic [N_CH-1:0] o_cmd,
    output logic [N_CH-1:0] o_fault,
    output logic [N_CH-1:0] o_blocked,
    output logic            o_busy
);

    localparam int PW = $clog2(N_CH);

    logic [N_CH-1:0]     w_occ, w_permit, w_cand, w_grant, w_open, w_busy_ch;
    logic [RING_MAX-1:0] w_occ_ext;
    logic [PW-1:0]       r_ptr, w_ptr_nxt, w_gidx;
    logic                w_found;
    logic [N_CH-1:0]     r_blocked;
    int                  w_idx;

    // A welded contact shows up through i_fb even when its coil is off.
    assign w_occ     = o_cmd | i_fb;
    assign w_occ_ext = {{(RING_MAX-N_CH){1'b0}}, w_occ};

    for (genvar k = 0; k < N_CH; k++) begin : g_permit
        assign w_permit[k] = !run_violation(w_occ_ext | (RING_MAX'(1) << k), N_CH, RUN_LIMIT);
    end

    assign w_cand = w_open & i_req & w_permit;

    always_comb begin
        w_grant = '0;
        w_found = 1'b0;
        w_gidx  = r_ptr;
        w_idx   = 0;
        for (int off = 0; off < N_CH; off++) begin
            w_idx = int'(r_ptr) + off;
            if (w_idx >= N_CH) w_idx = w_idx - N_CH;
            if (!w_found && w_cand[w_idx]) begin
                w_found        = 1'b1;
                w_grant[w_idx] = 1'b1;
                w_gidx         = PW'(w_idx);
            end
        end
        w_ptr_nxt = r_ptr;
        if (w_found) w_ptr_nxt = (w_gidx == PW'(N_CH - 1)) ? '0 : w_gidx + PW'(1);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr     <= '0;
            r_blocked <= '0;
        end else begin
            r_ptr     <= w_ptr_nxt;
            r_blocked <= w_open & i_req & ~w_permit;
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        ilk_channel_fsm #(
            .FB_TIMEOUT(FB_TIMEOUT)
        ) u_fsm (
            .i_clk      (i_clk),
            .i_rst_n    (i_rst_n),
            .i_grant    (w_grant[k]),
            .i_req      (i_req[k]),
            .i_fb       (i_fb[k]),
            .i_fault_clr(i_fault_clr),
            .o_open     (w_open[k]),
            .o_busy     (w_busy_ch[k]),
            .o_cmd      (o_cmd[k]),
            .o_fault    (o_fault[k])
        );
    end

    assign o_blocked = r_blocked;
    assign o_busy    = |w_busy_ch;

endmodule

// File: tb/tb_ring_interlock_ctrl.sv
// tb/tb_ring_interlock_ctrl.sv - randomized and directed checks of ring_interlock_ctrl against a behavioural model
module tb_ring_interlock_ctrl;

    localparam int N   = 8;
    localparam int RL  = 3;
    localparam int FBT = 16;

    localparam int M_OPEN = 0, M_CLOSING = 1, M_CLOSED = 2, M_OPENING = 3, M_FAULT = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] req = '0;
    logic [N-1:0] fb = '0;
    logic         clr = 1'b0;
    logic [N-1:0] o_cmd, o_fault, o_blocked;
    logic         o_busy;

    int vectors = 0;
    int errors  = 0;

    int           m_mode [N];
    int           m_dl   [N];
    int           m_ptr;
    int           cyc;
    logic [N-1:0] m_cmd, m_fault, m_blk;
    logic         m_busy;

    ring_interlock_ctrl #(.N_CH(N), .RUN_LIMIT(RL), .FB_TIMEOUT(FBT)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_fb(fb), .i_fault_clr(clr),
        .o_cmd(o_cmd), .o_fault(o_fault), .o_blocked(o_blocked), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    function automatic logic ring_bad(input logic [N-1:0] m);
        int run = 0;
        logic bad = 1'b0;
        for (int i = 0; i < 2 * N; i++) begin
            if (m[i % N]) run++; else run = 0;
            if (run >= RL) bad = 1'b1;
        end
        return bad;
    endfunction

    function automatic logic [N-1:0] onehot(input int k);
        logic [N-1:0] v = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin m_mode[k] = M_OPEN; m_dl[k] = 0; end
        m_ptr = 0; cyc = 0;
        m_cmd = '0; m_fault = '0; m_blk = '0; m_busy = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = '0; fb = '0; clr = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic tick();
        logic [N-1:0] occ, cand, blk;
        int g, idx;
        @(posedge clk);
        cyc++;
        occ = m_cmd | fb; cand = '0; blk = '0;
        for (int k = 0; k < N; k++)
            if (m_mode[k] == M_OPEN && req[k]) begin
                if (ring_bad(occ | onehot(k))) blk[k] = 1'b1; else cand[k] = 1'b1;
            end
        g = -1;
        for (int off = 0; off < N; off++) begin
            idx = (m_ptr + off) % N;
            if (g < 0 && cand[idx]) g = idx;
        end
        for (int k = 0; k < N; k++) begin
            case (m_mode[k])
                M_OPEN:    if (fb[k]) m_mode[k] = M_FAULT;
                           else if (g == k) begin m_mode[k] = M_CLOSING; m_dl[k] = cyc + FBT; end
                M_CLOSING: if (fb[k]) m_mode[k] = M_CLOSED;
                           else if (!req[k]) begin m_mode[k] = M_OPENING; m_dl[k] = cyc + FBT; end
                           else if (cyc == m_dl[k]) m_mode[k] = M_FAULT;
                M_CLOSED:  if (!req[k]) begin m_mode[k] = M_OPENING; m_dl[k] = cyc + FBT; end
                           else if (!fb[k]) m_mode[k] = M_FAULT;
                M_OPENING: if (!fb[k]) m_mode[k] = M_OPEN;
                           else if (cyc == m_dl[k]) m_mode[k] = M_FAULT;
                default: begin
`ifdef RING_ILK_STICKY_FAULT_EN
                    if (clr && !fb[k]) m_mode[k] = M_OPEN;
`else
                    if (!fb[k] && !req[k]) m_mode[k] = M_OPEN;
`endif
                end
            endcase
        end
        if (g >= 0) m_ptr = (g + 1) % N;
        m_blk = blk; m_busy = 1'b0;
        for (int k = 0; k < N; k++) begin
            m_cmd[k]   = (m_mode[k] == M_CLOSING) || (m_mode[k] == M_CLOSED);
            m_fault[k] = (m_mode[k] == M_FAULT);
            if (m_mode[k] == M_CLOSING || m_mode[k] == M_OPENING) m_busy = 1'b1;
        end
        #1;
        vectors += 4;
        if (o_cmd !== m_cmd) begin errors++; $display("FAIL cmd cyc=%0d got=%h want=%h", cyc, o_cmd, m_cmd); end
        if (o_fault !== m_fault) begin errors++; $display("FAIL fault cyc=%0d got=%h want=%h", cyc, o_fault, m_fault); end
        if (o_blocked !== m_blk) begin errors++; $display("FAIL blocked cyc=%0d got=%h want=%h", cyc, o_blocked, m_blk); end
        if (o_busy !== m_busy) begin errors++; $display("FAIL busy cyc=%0d got=%b want=%b", cyc, o_busy, m_busy); end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        vectors++;
        if ({o_cmd, o_fault, o_blocked, o_busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%h/%h/%h/%b want=0", o_cmd, o_fault, o_blocked, o_busy);
        end
    endtask

    task automatic test_single_close();
        do_reset();
        req = 8'h01;
        tick();
        vectors++;
        if (o_cmd !== 8'h01) begin errors++; $display("FAIL single_latency got=%h want=01", o_cmd); end
        tick(); tick();
        fb = 8'h01;
        tick();
        vectors++;
        if (o_busy !== 1'b0 || o_cmd !== 8'h01) begin
            errors++; $display("FAIL single_closed busy=%b cmd=%h want busy=0 cmd=01", o_busy, o_cmd);
        end
    endtask

    task automatic test_ring_block();
        do_reset();
        req = 8'h03;
        tick(); tick();
        fb = 8'h03;
        tick();
        req = 8'h07;
        tick();
        vectors++;
        if (o_blocked !== 8'h04 || o_cmd !== 8'h03) begin
            errors++; $display("FAIL block_2 blocked=%h cmd=%h want blocked=04 cmd=03", o_blocked, o_cmd);
        end
        req = 8'h83;
        tick();
        vectors++;
        if (o_blocked !== 8'h80 || o_cmd !== 8'h03) begin
            errors++; $display("FAIL block_wrap blocked=%h cmd=%h want blocked=80 cmd=03", o_blocked, o_cmd);
        end
    endtask

    task automatic test_all_requests();
        logic [N-1:0] exp_seq [5];
        exp_seq[0] = 8'h01; exp_seq[1] = 8'h03; exp_seq[2] = 8'h0B;
        exp_seq[3] = 8'h1B; exp_seq[4] = 8'h5B;
        do_reset();
        req = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            tick();
            vectors++;
            if (o_cmd !== exp_seq[(i < 5) ? i : 4] || ring_bad(o_cmd)) begin
                errors++; $display("FAIL grant_order step=%0d got=%h want=%h", i, o_cmd, exp_seq[(i < 5) ? i : 4]);
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        req = 8'h10;
        tick();
        for (int i = 0; i < FBT - 1; i++) tick();
        vectors++;
        if (o_fault[4] !== 1'b0 || o_cmd[4] !== 1'b1) begin
            errors++; $display("FAIL timeout_early fault=%b cmd=%b want fault=0 cmd=1", o_fault[4], o_cmd[4]);
        end
        tick();
        vectors++;
        if (o_fault[4] !== 1'b1 || o_cmd[4] !== 1'b0) begin
            errors++; $display("FAIL timeout_exact fault=%b cmd=%b want fault=1 cmd=0", o_fault[4], o_cmd[4]);
        end
    endtask

    task automatic test_dropout();
        do_reset();
        req = 8'h01;
        tick();
        fb = 8'h01;
        tick();
        fb = 8'h00;
        tick();
        vectors++;
        if (o_fault !== 8'h01) begin errors++; $display("FAIL dropout got=%h want=01", o_fault); end
`ifdef RING_ILK_STICKY_FAULT_EN
        req = 8'h00;
        tick(); tick();
        vectors++;
        if (o_fault !== 8'h01) begin errors++; $display("FAIL sticky_hold got=%h want=01", o_fault); end
        fb = 8'h01; clr = 1'b1;
        tick();
        clr = 1'b0;
        vectors++;
        if (o_fault !== 8'h01) begin errors++; $display("FAIL sticky_clr_fb got=%h want=01", o_fault); end
        fb = 8'h00; clr = 1'b1;
        tick();
        clr = 1'b0;
        vectors++;
        if (o_fault !== 8'h00) begin errors++; $display("FAIL sticky_clear got=%h want=00", o_fault); end
`else
        tick();
        vectors++;
        if (o_fault !== 8'h01) begin errors++; $display("FAIL auto_hold got=%h want=01", o_fault); end
        req = 8'h00;
        tick();
        vectors++;
        if (o_fault !== 8'h00) begin errors++; $display("FAIL auto_recover got=%h want=00", o_fault); end
`endif
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 8'h49;
        tick(); tick(); tick();
        vectors++;
        if (o_cmd !== 8'h49 || o_busy !== 1'b1) begin
            errors++; $display("FAIL three_closing cmd=%h busy=%b want cmd=49 busy=1", o_cmd, o_busy);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({o_cmd, o_fault, o_blocked, o_busy} !== '0) begin
            errors++; $display("FAIL async_reset got=%h/%h/%h/%b want=0", o_cmd, o_fault, o_blocked, o_busy);
        end
        do_reset();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 800; i++) begin
            tick();
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 5) == 0) req[k] = ~req[k];
                if ($urandom_range(0, 3) != 0) fb[k] = m_cmd[k];
                else if ($urandom_range(0, 7) == 0) fb[k] = ~fb[k];
            end
            clr = ($urandom_range(0, 7) == 0);
        end
        clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_close();
        test_ring_block();
        test_all_requests();
        test_timeout();
        test_dropout();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
